// File: rtl/peridot_board_eeprom_rw_if.sv
// Byte-layer handshake between the peridot_board_i2c engine and the EEPROM
// emulator. The engine drives the condition/done pulses and received data.
// The emulator drives the transmit byte and the ACK controls.
interface peridot_board_eeprom_rw_if;
  logic       condi_start;
  logic       condi_stop;
  logic       done_byte;
  logic       done_ack;
  logic [7:0] recv_data;
  logic       recv_ack;
  logic [7:0] send_data;
  logic       send_datavalid;
  logic       send_ack;
  logic       ack_waitrequest;

  modport master (
    output condi_start, condi_stop, done_byte, done_ack, recv_data, recv_ack,
    input  send_data, send_datavalid, send_ack, ack_waitrequest
  );

  modport slave (
    input  condi_start, condi_stop, done_byte, done_ack, recv_data, recv_ack,
    output send_data, send_datavalid, send_ack, ack_waitrequest
  );
endinterface

// File: rtl/peridot_board_eeprom_rw.sv
// Writable I2C serial-EEPROM emulator behind the peridot_board_i2c byte engine.
// It supports 1/2-byte word addressing, page-write wrap, write protect,
// current-address and sequential reads, and a busy period with ACK polling.
// A registered host port gives fabric logic read access to the storage.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | bus released, waiting for START
// DEVSEL   | waiting for the device-select byte
// ADDR_H   | waiting for the word-address high byte (2-byte mode only)
// ADDR_L   | waiting for the word-address low byte
// WRITE    | storing data bytes at the pointer, wrapping inside the page
// READ     | sending mem[pointer], pointer advances per byte
// IGNORE   | not addressed, NACKed, or master NACKed: stay silent
module peridot_board_eeprom_rw #(
  parameter logic [6:0] I2C_DEV_ADDRESS = 7'b1010000,
  parameter int         ADDR_BYTES      = 1,
  parameter int         DEPTH           = 256,
  parameter int         PAGE_SIZE       = 16,
  parameter int         WRITE_CYCLE     = 1000,
  parameter logic [7:0] INIT_VALUE      = 8'hff,
  localparam int        AW              = $clog2(DEPTH)
) (
  input  logic                            clock_sig,
  input  logic                            reset_sig,
  peridot_board_eeprom_rw_if.slave        bus,
  input  logic                            wp,
  output logic                            busy,
  input  logic [AW-1:0]                   host_addr,
  output logic [7:0]                      host_rddata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DEVSEL = 3'd1;
  localparam logic [2:0] S_ADDR_H = 3'd2;
  localparam logic [2:0] S_ADDR_L = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_READ   = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;

  localparam int             CW       = (WRITE_CYCLE > 1) ? $clog2(WRITE_CYCLE + 1) : 1;
  localparam logic [CW-1:0]  CYC_LOAD = CW'(WRITE_CYCLE);
  localparam logic [AW-1:0]  PMASK    = AW'(PAGE_SIZE - 1);
  localparam logic [AW-1:0]  LOW_BYTE = AW'(8'hff);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nxt;
  logic [AW-1:0] ptr_inc;
  logic          ack_nxt;
  logic          mem_we;
  logic          wrote_set;
  logic          wait_set;
  logic          wrote_any;
  logic [CW-1:0] busy_cnt;
  logic [7:0]    mem [DEPTH];

  assign ptr_inc            = ptr + AW'(1);
  assign busy               = (busy_cnt != '0);
  assign bus.send_datavalid = bus.recv_ack && (state == S_READ);

  // Next-state, ACK and pointer decisions; STOP outranks START outranks bytes.
  always_comb begin
    state_nxt = state;
    ack_nxt   = bus.send_ack;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    wrote_set = 1'b0;
    wait_set  = 1'b0;
    if (bus.condi_stop) begin
      state_nxt = S_IDLE;
      ack_nxt   = 1'b0;
    end else if (bus.condi_start) begin
      state_nxt = S_DEVSEL;
      ack_nxt   = 1'b0;
    end else begin
      // ACK slot is over; nothing is acknowledged until the next byte decides
      if (bus.done_ack) ack_nxt = 1'b0;
      case (state)
        S_DEVSEL: begin
          if (bus.done_byte) begin
            if ((bus.recv_data[7:1] != I2C_DEV_ADDRESS) || busy) begin
              state_nxt = S_IGNORE;
              ack_nxt   = 1'b0;
            end else if (bus.recv_data[0]) begin
              state_nxt = S_READ;
              ack_nxt   = 1'b1;
            end else begin
              state_nxt = (ADDR_BYTES == 2) ? S_ADDR_H : S_ADDR_L;
              ack_nxt   = 1'b1;
            end
          end
        end
        S_ADDR_H: begin
          if (bus.done_byte) begin
            // high byte lands above bit 7; bits beyond the storage width fall off
            ptr_nxt   = AW'({bus.recv_data, 8'h00}) | (ptr & LOW_BYTE);
            ack_nxt   = 1'b1;
            state_nxt = S_ADDR_L;
          end
        end
        S_ADDR_L: begin
          if (bus.done_byte) begin
            // in 1-byte mode the upper pointer bits are cleared, not inherited
            if (ADDR_BYTES == 2) ptr_nxt = (ptr & ~LOW_BYTE) | AW'(bus.recv_data);
            else                 ptr_nxt = AW'(bus.recv_data);
            ack_nxt   = 1'b1;
            state_nxt = S_WRITE;
          end
        end
        S_WRITE: begin
          if (bus.done_byte) begin
            mem_we    = !wp;
            wrote_set = 1'b1;
            ack_nxt   = 1'b1;
            ptr_nxt   = (ptr & ~PMASK) | (ptr_inc & PMASK);
          end
        end
        S_READ: begin
          if (bus.done_byte) begin
            ptr_nxt  = ptr_inc;
            wait_set = 1'b1;
          end
          if (bus.done_ack) begin
            ack_nxt = 1'b0;
            if (!bus.recv_ack) state_nxt = S_IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  // Control registers: state, pointer, ACK outputs, read data, busy timer.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state               <= S_IDLE;
      ptr                 <= '0;
      bus.send_ack        <= 1'b0;
      bus.send_data       <= 8'h00;
      bus.ack_waitrequest <= 1'b0;
      wrote_any           <= 1'b0;
      busy_cnt            <= '0;
    end else begin
      state               <= state_nxt;
      ptr                 <= ptr_nxt;
      bus.send_ack        <= ack_nxt;
      bus.ack_waitrequest <= wait_set;
      // send_data trails the pointer by one clock; waitrequest covers that gap
      if (state_nxt == S_READ) bus.send_data <= mem[ptr];
      if (bus.condi_stop)  wrote_any <= 1'b0;
      else if (wrote_set)  wrote_any <= 1'b1;
      if (bus.condi_stop && wrote_any && (WRITE_CYCLE != 0)) busy_cnt <= CYC_LOAD;
      else if (busy_cnt != '0)                              busy_cnt <= busy_cnt - CW'(1);
    end
  end

  // Storage array; reset restores every byte so no partial write survives.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= INIT_VALUE;
    end else if (mem_we) begin
      mem[ptr] <= bus.recv_data;
    end
  end

  // Host read port; a same-cycle store is seen one clock later (old byte first).
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) host_rddata <= 8'h00;
    else           host_rddata <= mem[host_addr];
  end

endmodule

// File: doc/peridot_board_eeprom_rw.md
Name: peridot_board_eeprom_rw

Overview:
Parametrised next-generation I2C serial-EEPROM emulator FSM. It sits behind the existing peridot_board_i2c byte-layer engine. Unlike the read-only UID ROM emulator, it supports:
- writable internal storage of configurable depth,
- 1- or 2-byte word addressing,
- page-write wrap and a write-protect input,
- current-address reads,
- an emulated write-cycle busy period with ACK polling.

A host-side read port exposes the storage to fabric logic.

Parameters:
I2C_DEV_ADDRESS, 7'b1010000, 7-bit device address matched in devsel bytes
ADDR_BYTES, 1, word-address bytes after devsel-write (1 or 2)
DEPTH, 256, storage bytes; power of 2, 16..65536; AW = log2(DEPTH)
PAGE_SIZE, 16, page-write wrap boundary; power of 2, <= DEPTH
WRITE_CYCLE, 1000, clocks of busy after a committed write (0 = no busy)
INIT_VALUE, 8'hff, reset/initial content of every byte

Ports:
clock_sig  in  1  clock, all logic on rising edge
reset_sig  in  1  asynchronous, active-high reset
condi_start  in  1  1-clk pulse: START or repeated START detected
condi_stop  in  1  1-clk pulse: STOP detected
done_byte  in  1  1-clk pulse: 8 bits received/sent
done_ack  in  1  1-clk pulse: ACK bit slot finished
recv_data  in  8  last received byte, valid with done_byte
recv_ack  in  1  master ACK (1) / NACK (0) after a sent byte
send_data  out  8  byte to transmit in read mode
send_datavalid  out  1  send_data shall be driven onto SDA
send_ack  out  1  1 = slave ACKs the current byte
ack_waitrequest  out  1  1 = engine stretches SCL before the ACK slot
wp  in  1  write protect; 1 = writes ACKed but discarded
busy  out  1  write cycle in progress
host_addr  in  AW  fabric read address
host_rddata  out  8  mem[host_addr], registered, 1-clk latency

Behaviour:
- Reset values: state IDLE, send_ack 0, send_data 8'h00, ack_waitrequest 0, busy 0, word pointer 0, host_rddata 8'h00, memory INIT_VALUE. Reset mid-transfer aborts silently; no partial write survives.
- States: IDLE, DEVSEL, ADDR_H, ADDR_L, WRITE, READ, IGNORE.
- condi_stop has top priority in any state: go to IDLE, send_ack 0. If at least one data byte was accepted in WRITE, start the write cycle: busy = 1 for WRITE_CYCLE clocks.
- condi_start in any state: go to DEVSEL, send_ack 0.
- DEVSEL, on done_byte:
  - Address mismatch: IGNORE, NACK.
  - Match while busy: IGNORE, NACK (ACK polling).
  - Match, R/W = 0: ACK; go to ADDR_H if ADDR_BYTES = 2, else ADDR_L.
  - Match, R/W = 1: ACK; go to READ from the current pointer (current-address read).
- ADDR_H, on done_byte: latch pointer high byte (bits above AW dropped); ACK; go to ADDR_L.
- ADDR_L, on done_byte: latch pointer low byte (truncated to AW); ACK; go to WRITE.
- WRITE, on done_byte:
  - If wp = 0: store recv_data at the pointer.
  - Always ACK, then advance the pointer low log2(PAGE_SIZE) bits only (page wrap; upper bits fixed).
  - A repeated START then devsel-read reads from the current pointer (random read). Bytes already written stay written and start the busy period at the next STOP.
- READ:
  - send_data is registered from mem[pointer].
  - ack_waitrequest = 1 from pointer change until send_data is updated (exactly 1 clk).
  - send_datavalid = recv_ack && state == READ.
  - On done_byte: pointer +1, wrapping at DEPTH.
  - On done_ack: send_ack 0 (slave never ACKs in read).
  - Master NACK: the block stops driving until STOP or START.
- IGNORE: all outputs idle until START or STOP.
- Pointer persists across transactions; it is reset only by reset_sig.
- Simultaneous write-store and host read of the same address: host_rddata returns the old byte.
- busy counter saturates at 0. A new write cycle cannot start while busy, because devsel is NACKed.

Test Plan:
- Byte write then random read: START, A0, 05, 3C, STOP; wait busy = 0; then START, A0, 05, rSTART, A1 with master NACK → read byte = 3C. host_addr = 5 also gives 3C.
- Page wrap (PAGE_SIZE 16): write 18 bytes 00..11 starting at 0x0E → mem[0x0E] = 10, mem[0x0F] = 11, mem[0x00..0x0D] = 02..0F; the next page is untouched (FF).
- ACK polling (WRITE_CYCLE 1000): after a write STOP, devsel A0 within 1000 clk → NACK; after the busy period → ACK; busy falls exactly 1000 clk after STOP.
- Write protect: wp = 1, write 55 to 0x20 → all bytes ACKed, mem[0x20] remains FF, busy still asserted.
- Sequential and current-address read, DEPTH 256: pointer at 0xFE, read 3 bytes → mem[FE], mem[FF], mem[00]; a following current-address read returns mem[01].
- Mismatch and reset: devsel A2 → NACK, no state change. reset_sig asserted mid-WRITE → outputs return to reset values; the pointer is 0 after release.
